// File: rtl/bcd_count_7seg.sv
// Two-digit BCD up/down counter stepped by a TICK_DIV prescaler, with registered 7-segment decode (one cycle behind bcd).
// Optional leading-zero blanking of the tens digit when BCD_BLANK_EN is defined.
module bcd_count_7seg #(
   parameter int TICK_DIV = 15000,
   parameter int TBITS    = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [7:0]  load_val,
   output logic [7:0]  bcd,
   output logic [13:0] both7seg,
   output logic        wrap,
   output logic        load_err
);

   localparam logic [TBITS-1:0] PC_LAST = TBITS'(TICK_DIV - 1);
`ifdef BCD_BLANK_EN
   localparam logic [13:0] SEG_RST = 14'h003F;
`else
   localparam logic [13:0] SEG_RST = 14'h1FBF;
`endif

   logic [TBITS-1:0] pc;
   logic             tick;
   logic             load_ok;
   logic [3:0]       nxt_tens;
   logic [3:0]       nxt_units;
   logic             nxt_wrap;
   logic [13:0]      seg_dec;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   assign tick    = en && (pc == PC_LAST);
   assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

   // Next BCD value for one step in the current direction; nxt_wrap flags 99<->00.
   always_comb begin
      nxt_tens  = bcd[7:4];
      nxt_units = bcd[3:0];
      nxt_wrap  = 1'b0;
      if (up) begin
         if (bcd[3:0] == 4'd9) begin
            nxt_units = 4'd0;
            if (bcd[7:4] == 4'd9) begin
               nxt_tens = 4'd0;
               nxt_wrap = 1'b1;
            end else begin
               nxt_tens = bcd[7:4] + 4'd1;
            end
         end else begin
            nxt_units = bcd[3:0] + 4'd1;
         end
      end else begin
         if (bcd[3:0] == 4'd0) begin
            nxt_units = 4'd9;
            if (bcd[7:4] == 4'd0) begin
               nxt_tens = 4'd9;
               nxt_wrap = 1'b1;
            end else begin
               nxt_tens = bcd[7:4] - 4'd1;
            end
         end else begin
            nxt_units = bcd[3:0] - 4'd1;
         end
      end
   end

   always_comb begin
      seg_dec = {seg7(bcd[7:4]), seg7(bcd[3:0])};
`ifdef BCD_BLANK_EN
      if (bcd[7:4] == 4'd0) begin
         seg_dec[13:7] = 7'h00;
      end
`endif
   end

   // Load outranks the tick: the step is dropped and the prescaler restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= '0;
         bcd      <= 8'h00;
         wrap     <= 1'b0;
         load_err <= 1'b0;
         both7seg <= SEG_RST;
      end else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
         both7seg <= seg_dec;
         if (load) begin
            pc <= '0;
            if (load_ok) begin
               bcd <= load_val;
            end else begin
               load_err <= 1'b1;
            end
         end else if (en) begin
            if (tick) begin
               pc   <= '0;
               bcd  <= {nxt_tens, nxt_units};
               wrap <= nxt_wrap;
            end else begin
               pc <= pc + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/bcd_count_7seg.md
BCD_COUNT_7SEG -- requirements
Module: bcd_count_7seg

Interface
REQ-001 Parameter TICK_DIV, default 15000: clk cycles per count step; legal range 2..16383.
REQ-002 Parameter TBITS, default 14: prescaler width; must satisfy 2^TBITS >= TICK_DIV.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; gates the prescaler and stepping.
REQ-006 up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 load  input  1  synchronous load strobe for load_val.
REQ-008 load_val  input  8  BCD value to load: [7:4] tens, [3:0] units.
REQ-009 bcd  output  8  current BCD count: [7:4] tens, [3:0] units.
REQ-010 both7seg  output  14  segment patterns: [13:7] tens digit, [6:0] units digit; this feeds the downstream two-digit display multiplexer.
REQ-011 wrap  output  1  one-cycle pulse when a step wraps 99->00 (up) or 00->99 (down).
REQ-012 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 Prescaler pc counts 0..TICK_DIV-1 while en=1. It returns to 0 after TICK_DIV-1 and holds its value while en=0.
REQ-014 Internal tick asserts for exactly the one cycle in which en=1 and pc=TICK_DIV-1.
REQ-015 On tick with up=1, units increments 0..9. From 9, units goes to 0 and tens increments 0..9. 99 steps to 00.
REQ-016 On tick with up=0, units decrements. From 0, units goes to 9 and tens decrements. 00 steps to 99.
REQ-017 wrap is registered and asserts in the cycle after the edge on which bcd makes a 99<->00 wrap transition; it stays low otherwise.
REQ-018 load=1 takes priority over tick in the same cycle. The step is discarded and pc is cleared to 0.
REQ-019 When both load_val nibbles are <=9, the load sets bcd=load_val on that edge.
REQ-020 When either load_val nibble is >9, bcd is unchanged, pc is still cleared, and load_err pulses high for the next cycle only.
REQ-021 load is level-sampled: holding load high reloads every cycle and keeps pc at 0.
REQ-022 Segment encoding is active-high, bit0=a through bit6=g. Digits 0-9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-023 both7seg is a register holding the decode of bcd, so it lags bcd by exactly one clk cycle.
REQ-024 A bcd digit outside 0-9 cannot occur. The decoder maps any such value to 00 (blank).
REQ-025 TICK_DIV and the counting rules fully define the tick spacing. en toggling never produces two ticks closer than TICK_DIV enabled cycles.

Reset
REQ-026 rst=1 immediately forces the following, with no clock required: pc=0, bcd=00, wrap=0, load_err=0, both7seg=14'h1FBF (both digits "0"), or 14'h003F under REQ-029.
REQ-027 Reset asserted mid-count or mid-load discards any pending step, load or pulse. Counting resumes from 00 with a full TICK_DIV period after rst deasserts.
REQ-028 While rst=1, all other inputs are ignored.

Configuration
REQ-029 With macro BCD_BLANK_EN defined, leading-zero blanking is applied: when tens=0, both7seg[13:7]=00, including at reset. Units are never blanked.
REQ-030 Without BCD_BLANK_EN, the tens digit always shows its decoded pattern (tens=0 gives 3F). Interface and timing are identical in both builds.

Verification
REQ-031 TICK_DIV=4, en=1, up=1 from reset, 40 cycles -> bcd steps 00,01,...,09,10 every 4 cycles. both7seg follows one cycle later (10 -> 14'h033F without blanking).
REQ-032 TICK_DIV=4, load 0x99, up=1, wait 4 cycles -> bcd=00 and wrap pulses for 1 cycle. Then up=0, wait 4 cycles -> bcd=99 and wrap pulses again.
REQ-033 load_val=0x3A with load=1 -> bcd unchanged, load_err=1 for exactly one cycle, pc=0.
REQ-034 load=1 asserted in the tick cycle with load_val=0x42 -> bcd=42 with no step applied. The next step occurs exactly TICK_DIV cycles later.
REQ-035 rst pulsed asynchronously between clock edges at bcd=57 -> bcd=00 and both7seg=14'h1FBF (14'h003F with BCD_BLANK_EN) before the next edge.
REQ-036 en dropped for 10 cycles at pc=2 -> pc holds at 2. The tick occurs TICK_DIV-2 enabled cycles after en returns.
